// File: rtl/cmd_cfg_pkg.sv
// cmd_cfg_pkg: shared opcodes, response codes, register offsets and FSM
// states for the cmd_cfg_mc command/config unit.
package cmd_cfg_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_DUMP = 2'b10,
        OP_RSVD = 2'b11
    } opcode_e;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    // Register offsets relative to B = NUM_CH+1 (the first register after
    // the per-channel trigger configs).
    localparam int OFF_DEC  = 0;
    localparam int OFF_VIH  = 1;
    localparam int OFF_VIL  = 2;
    localparam int OFF_MH   = 3;
    localparam int OFF_ML   = 4;
    localparam int OFF_KH   = 5;
    localparam int OFF_KL   = 6;
    localparam int OFF_BH   = 7;
    localparam int OFF_BL   = 8;
    localparam int OFF_TPH  = 9;
    localparam int OFF_TPL  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SENT,
        S_DUMP_RD,
        S_DUMP_SEND,
        S_DUMP_WAIT
    } state_e;

endpackage

// File: rtl/cmd_cfg_regfile.sv
// cmd_cfg_regfile: trigger/config register storage, address decode, reset
// values and the capture-done sticky bit in trig_cfg[4].
module cmd_cfg_regfile
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [5:0]            addr,
    input  logic [7:0]            wdata,
    input  logic                  set_capture_done,
    output logic [7:0]            rd_data,
    output logic                  unmapped,
    output logic [5:0]            trig_cfg,
    output logic [NUM_CH*5-1:0]   ch_trig_cfg,
    output logic [3:0]            decimator,
    output logic [7:0]            VIH,
    output logic [7:0]            VIL,
    output logic [7:0]            matchH,
    output logic [7:0]            matchL,
    output logic [7:0]            maskH,
    output logic [7:0]            maskL,
    output logic [7:0]            baud_cntH,
    output logic [7:0]            baud_cntL,
    output logic [ADDR_W-1:0]     trig_pos
);

    localparam int B = NUM_CH + 1;

    logic [5:0]              trig_cfg_q, trig_cfg_d;
    logic [NUM_CH-1:0][4:0]  ch_q, ch_d;
    logic [3:0]              dec_q, dec_d;
    logic [7:0]              vih_q, vih_d, vil_q, vil_d;
    logic [7:0]              mh_q, mh_d, ml_q, ml_d;
    logic [7:0]              kh_q, kh_d, kl_q, kl_d;
    logic [7:0]              bh_q, bh_d, bl_q, bl_d;
    logic [ADDR_W-1:0]       tp_q, tp_d;
    logic [15:0]             tp16, tp16_d;
    logic [31:0]             a;

    assign a    = {26'd0, addr};
    assign tp16 = 16'(tp_q);

    // Decode: read mux, unmapped flag and write-enables share one address match.
    always_comb begin
        rd_data    = '0;
        unmapped   = 1'b0;
        trig_cfg_d = trig_cfg_q;
        ch_d       = ch_q;
        dec_d      = dec_q;
        vih_d      = vih_q;
        vil_d      = vil_q;
        mh_d       = mh_q;
        ml_d       = ml_q;
        kh_d       = kh_q;
        kl_d       = kl_q;
        bh_d       = bh_q;
        bl_d       = bl_q;
        tp16_d     = tp16;
        if (a == 32'd0) begin
            rd_data = {2'b0, trig_cfg_q};
            if (wr_en) trig_cfg_d = wdata[5:0];
        end else if (a <= 32'(NUM_CH)) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (a == 32'(n + 1)) begin
                    rd_data = {3'b0, ch_q[n]};
                    if (wr_en) ch_d[n] = wdata[4:0];
                end
            end
        end else begin
            case (a - 32'(B))
                OFF_DEC: begin rd_data = {4'b0, dec_q}; if (wr_en) dec_d = wdata[3:0]; end
                OFF_VIH: begin rd_data = vih_q;         if (wr_en) vih_d = wdata;      end
                OFF_VIL: begin rd_data = vil_q;         if (wr_en) vil_d = wdata;      end
                OFF_MH:  begin rd_data = mh_q;          if (wr_en) mh_d  = wdata;      end
                OFF_ML:  begin rd_data = ml_q;          if (wr_en) ml_d  = wdata;      end
                OFF_KH:  begin rd_data = kh_q;          if (wr_en) kh_d  = wdata;      end
                OFF_KL:  begin rd_data = kl_q;          if (wr_en) kl_d  = wdata;      end
                OFF_BH:  begin rd_data = bh_q;          if (wr_en) bh_d  = wdata;      end
                OFF_BL:  begin rd_data = bl_q;          if (wr_en) bl_d  = wdata;      end
                OFF_TPH: begin rd_data = tp16[15:8];    if (wr_en) tp16_d[15:8] = wdata; end
                OFF_TPL: begin rd_data = tp16[7:0];     if (wr_en) tp16_d[7:0]  = wdata; end
                default: unmapped = 1'b1;
            endcase
        end
        // Capture-done is sticky: a same-cycle host write cannot clear it.
        trig_cfg_d[4] = trig_cfg_d[4] | set_capture_done;
        tp_d = tp16_d[ADDR_W-1:0];
    end

    // Register state with synchronous reset to the documented defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_cfg_q <= '0;
            ch_q       <= '0;
            dec_q      <= '0;
            vih_q      <= 8'hAA;
            vil_q      <= 8'h55;
            mh_q       <= '0;
            ml_q       <= '0;
            kh_q       <= '0;
            kl_q       <= '0;
            bh_q       <= '0;
            bl_q       <= '0;
            tp_q       <= '0;
        end else begin
            trig_cfg_q <= trig_cfg_d;
            ch_q       <= ch_d;
            dec_q      <= dec_d;
            vih_q      <= vih_d;
            vil_q      <= vil_d;
            mh_q       <= mh_d;
            ml_q       <= ml_d;
            kh_q       <= kh_d;
            kl_q       <= kl_d;
            bh_q       <= bh_d;
            bl_q       <= bl_d;
            tp_q       <= tp_d;
        end
    end

    assign trig_cfg    = trig_cfg_q;
    assign ch_trig_cfg = ch_q;
    assign decimator   = dec_q;
    assign VIH         = vih_q;
    assign VIL         = vil_q;
    assign matchH      = mh_q;
    assign matchL      = ml_q;
    assign maskH       = kh_q;
    assign maskL       = kl_q;
    assign baud_cntH   = bh_q;
    assign baud_cntL   = bl_q;
    assign trig_pos    = tp_q;

endmodule

// File: rtl/cmd_cfg_mc.sv
// cmd_cfg_mc: host command decoder, one-byte responder and multi-channel
// RAM dumper. Optional macro CMD_CFG_DUMP_ABORT_EN lets an opcode-11
// command abort a running dump after the byte in flight.
module cmd_cfg_mc
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int ADDR_W  = $clog2(ENTRIES),
    parameter int DATA_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              cmd,
    input  logic                     cmd_rdy,
    output logic                     clr_cmd_rdy,
    output logic [7:0]               resp,
    output logic                     send_resp,
    input  logic                     resp_sent,
    input  logic                     set_capture_done,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [NUM_CH*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]        addr_ptr,
    output logic [5:0]               trig_cfg,
    output logic [NUM_CH*5-1:0]      ch_trig_cfg,
    output logic [3:0]               decimator,
    output logic [7:0]               VIH,
    output logic [7:0]               VIL,
    output logic [7:0]               matchH,
    output logic [7:0]               matchL,
    output logic [7:0]               maskH,
    output logic [7:0]               maskL,
    output logic [7:0]               baud_cntH,
    output logic [7:0]               baud_cntL,
    output logic [ADDR_W-1:0]        trig_pos
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

    state_e             state_q, state_d;
    logic [7:0]         resp_q, resp_d;
    logic               send_resp_q, send_resp_d;
    logic               clr_q, clr_d;
    logic [ADDR_W-1:0]  addr_ptr_q, addr_ptr_d;
    logic [ADDR_W-1:0]  count_q, count_d;
    logic [5:0]         ch_q, ch_d;
    logic               wr_en;
    logic [7:0]         rd_data;
    logic               unmapped;
    logic [DATA_W-1:0]  rbyte;
    opcode_e            op;
    logic [31:0]        cmd_addr;

    assign op       = opcode_e'(cmd[15:14]);
    assign cmd_addr = {26'd0, cmd[13:8]};

    cmd_cfg_regfile #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_regs (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .addr             (cmd[13:8]),
        .wdata            (cmd[7:0]),
        .set_capture_done (set_capture_done),
        .rd_data          (rd_data),
        .unmapped         (unmapped),
        .trig_cfg         (trig_cfg),
        .ch_trig_cfg      (ch_trig_cfg),
        .decimator        (decimator),
        .VIH              (VIH),
        .VIL              (VIL),
        .matchH           (matchH),
        .matchL           (matchL),
        .maskH            (maskH),
        .maskL            (maskL),
        .baud_cntH        (baud_cntH),
        .baud_cntL        (baud_cntL),
        .trig_pos         (trig_pos)
    );

    // Pick the selected channel's byte out of the packed RAM read bus.
    always_comb begin
        rbyte = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_q == 6'(n + 1)) rbyte = rdata[n*DATA_W +: DATA_W];
        end
    end

    // Command FSM: next state, response byte and handshake pulses.
    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        send_resp_d = 1'b0;
        clr_d       = 1'b0;
        addr_ptr_d  = addr_ptr_q;
        count_d     = count_q;
        ch_d        = ch_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_rdy) begin
                    clr_d       = 1'b1;
                    send_resp_d = 1'b1;
                    state_d     = S_WAIT_SENT;
                    case (op)
                        OP_RD: resp_d = unmapped ? NAK : rd_data;
                        OP_WR: begin
                            wr_en  = ~unmapped;
                            resp_d = unmapped ? NAK : ACK;
                        end
                        OP_DUMP: begin
                            if (cmd_addr != 32'd0 && cmd_addr <= 32'(NUM_CH)) begin
                                send_resp_d = 1'b0;
                                ch_d        = cmd[13:8];
                                addr_ptr_d  = waddr;
                                count_d     = '0;
                                state_d     = S_DUMP_RD;
                            end else begin
                                resp_d = NAK;
                            end
                        end
                        default: resp_d = NAK;
                    endcase
                end
            end
            S_WAIT_SENT: begin
                if (resp_sent) state_d = S_IDLE;
            end
            S_DUMP_RD: state_d = S_DUMP_SEND;
            S_DUMP_SEND: begin
                resp_d      = rbyte;
                send_resp_d = 1'b1;
                state_d     = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (resp_sent) begin
                    if (count_q == LAST) begin
                        state_d = S_IDLE;
`ifdef CMD_CFG_DUMP_ABORT_EN
                    end else if (cmd_rdy && op == OP_RSVD) begin
                        clr_d       = 1'b1;
                        resp_d      = NAK;
                        send_resp_d = 1'b1;
                        state_d     = S_WAIT_SENT;
`endif
                    end else begin
                        count_d    = count_q + ADDR_W'(1);
                        addr_ptr_d = (addr_ptr_q == LAST) ? '0 : addr_ptr_q + ADDR_W'(1);
                        state_d    = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            resp_q      <= '0;
            send_resp_q <= 1'b0;
            clr_q       <= 1'b0;
            addr_ptr_q  <= '0;
            count_q     <= '0;
            ch_q        <= '0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            send_resp_q <= send_resp_d;
            clr_q       <= clr_d;
            addr_ptr_q  <= addr_ptr_d;
            count_q     <= count_d;
            ch_q        <= ch_d;
        end
    end

    assign resp        = resp_q;
    assign send_resp   = send_resp_q;
    assign clr_cmd_rdy = clr_q;
    assign addr_ptr    = addr_ptr_q;

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// tb_cmd_cfg_mc: randomized self-checking bench for cmd_cfg_mc with a
// register-map reference model and a behavioural RAM/UART model.
module tb_cmd_cfg_mc;

    localparam int NUM_CH  = 5;
    localparam int ENTRIES = 384;
    localparam int ADDR_W  = $clog2(ENTRIES);
    localparam int NREG    = NUM_CH + 12;   // addresses 0..B+10

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [15:0]            cmd = '0;
    logic                   cmd_rdy = 1'b0;
    logic                   clr_cmd_rdy;
    logic [7:0]             resp;
    logic                   send_resp;
    logic                   resp_sent = 1'b0;
    logic                   set_capture_done = 1'b0;
    logic [ADDR_W-1:0]      waddr = '0;
    logic [NUM_CH*8-1:0]    rdata = '0;
    logic [ADDR_W-1:0]      addr_ptr;
    logic [5:0]             trig_cfg;
    logic [NUM_CH*5-1:0]    ch_trig_cfg;
    logic [3:0]             decimator;
    logic [7:0]             VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
    logic [ADDR_W-1:0]      trig_pos;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem [NUM_CH][ENTRIES];
    logic [7:0] ref_reg [NREG];

    cmd_cfg_mc #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
        .set_capture_done(set_capture_done), .waddr(waddr), .rdata(rdata),
        .addr_ptr(addr_ptr), .trig_cfg(trig_cfg), .ch_trig_cfg(ch_trig_cfg),
        .decimator(decimator), .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL),
        .maskH(maskH), .maskL(maskL), .baud_cntH(baud_cntH), .baud_cntL(baud_cntL),
        .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: one cycle of read latency.
    always @(posedge clk) begin
        for (int n = 0; n < NUM_CH; n++) rdata[n*8 +: 8] <= mem[n][addr_ptr];
    end

    // Register width as a mask, from the register map.
    function automatic logic [7:0] wmask(input int a);
        if (a == 0) return 8'h3F;
        if (a <= NUM_CH) return 8'h1F;
        if (a == NUM_CH + 1) return 8'h0F;
        if (a == NUM_CH + 10) return 8'((1 << (ADDR_W - 8)) - 1);
        return 8'hFF;
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < NREG; i++) ref_reg[i] = 8'h00;
        ref_reg[NUM_CH + 2] = 8'hAA;
        ref_reg[NUM_CH + 3] = 8'h55;
    endfunction

    // Expected response for a register command; updates the model.
    function automatic logic [7:0] ref_cmd(input logic [1:0] op, input int a,
                                           input logic [7:0] d, input bit s);
        logic [7:0] e;
        e = 8'hEE;
        if (op == 2'b00 && a < NREG) e = ref_reg[a];
        if (op == 2'b01 && a < NREG) begin
            ref_reg[a] = d & wmask(a);
            e = 8'hA5;
        end
        if (s) ref_reg[0] = ref_reg[0] | 8'h10;
        return e;
    endfunction

    // Wait for the next response byte, releasing cmd_rdy once accepted.
    task automatic get_resp(output logic [7:0] b, output bit ok, output bit saw_clr);
        b = '0; ok = 1'b0; saw_clr = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) begin cmd_rdy = 1'b0; saw_clr = 1'b1; end
            if (send_resp) begin b = resp; ok = 1'b1; break; end
        end
    endtask

    task automatic ack();
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        cmd = {op, a, d};
        cmd_rdy = 1'b1;
    endtask

    // Register command with model comparison.
    task automatic reg_cmd(input logic [1:0] op, input int a, input logic [7:0] d, input bit s);
        logic [7:0] b, e;
        bit ok, c;
        start_cmd(op, 6'(a), d);
        set_capture_done = s;
        get_resp(b, ok, c);
        e = ref_cmd(op, a, d, s);
        n_chk++;
        if (!ok) begin
            n_fail++; cmd_rdy = 1'b0;
            $display("FAIL reg_cmd_timeout op=%0d addr=%0d: no send_resp, required resp %h", op, a, e);
        end else begin
            ack();
            if (b !== e || !c) begin
                n_fail++;
                $display("FAIL reg_cmd op=%0d addr=%0d: got %h clr=%0d, required %h clr=1", op, a, b, c, e);
            end
        end
        set_capture_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ref_reset();
        n_chk++;
        if ({resp, send_resp, clr_cmd_rdy, addr_ptr} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctl: resp=%h send=%b clr=%b ptr=%0d, required all 0", resp, send_resp, clr_cmd_rdy, addr_ptr);
        end
        n_chk++;
        if (VIH !== 8'hAA || VIL !== 8'h55 || trig_cfg !== 6'h00 || trig_pos !== '0 || ch_trig_cfg !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: VIH=%h VIL=%h trig=%h tpos=%h ch=%h, required AA 55 0 0 0", VIH, VIL, trig_cfg, trig_pos, ch_trig_cfg);
        end
    endtask

    task automatic check_ports(input string tag);
        logic [NUM_CH*5-1:0] ech;
        for (int c = 0; c < NUM_CH; c++) ech[c*5 +: 5] = ref_reg[c+1][4:0];
        n_chk++;
        if (trig_cfg !== ref_reg[0][5:0] || ch_trig_cfg !== ech || decimator !== ref_reg[NUM_CH+1][3:0]
            || VIH !== ref_reg[NUM_CH+2] || VIL !== ref_reg[NUM_CH+3] || matchH !== ref_reg[NUM_CH+4]
            || matchL !== ref_reg[NUM_CH+5] || maskH !== ref_reg[NUM_CH+6] || maskL !== ref_reg[NUM_CH+7]
            || baud_cntH !== ref_reg[NUM_CH+8] || baud_cntL !== ref_reg[NUM_CH+9]
            || trig_pos !== {ref_reg[NUM_CH+10][ADDR_W-9:0], ref_reg[NUM_CH+11]}) begin
            n_fail++;
            $display("FAIL ports_%s: trig=%h ch=%h dec=%h VIH=%h tpos=%h, required trig=%h ch=%h dec=%h VIH=%h",
                     tag, trig_cfg, ch_trig_cfg, decimator, VIH, trig_pos, ref_reg[0][5:0], ech,
                     ref_reg[NUM_CH+1][3:0], ref_reg[NUM_CH+2]);
        end
    endtask

    task automatic test_write_read();
        for (int a = 0; a < NREG; a++) reg_cmd(2'b01, a, 8'(a + 1), 1'b1);
        for (int a = 0; a < NREG; a++) reg_cmd(2'b00, a, 8'h00, 1'b1);
        check_ports("wr");
    endtask

    task automatic test_unmapped();
        reg_cmd(2'b01, 32, 8'($urandom), 1'b0);
        reg_cmd(2'b00, 32, 8'h00, 1'b0);
        reg_cmd(2'b01, 63, 8'($urandom), 1'b0);
        for (int a = 0; a < NREG; a++) reg_cmd(2'b00, a, 8'h00, 1'b0);
        check_ports("unmapped");
    endtask

    task automatic test_random();
        logic [1:0] op;
        int a;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? $urandom_range(NREG, 63) : $urandom_range(0, NREG - 1);
            reg_cmd(op, a, 8'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        check_ports("random");
    endtask

    task automatic fill_ram();
        logic [7:0] off;
        for (int c = 0; c < NUM_CH; c++) begin
            off = 8'($urandom);
            for (int k = 0; k < ENTRIES; k++) mem[c][k] = 8'(k) + off;
        end
    endtask

    // Full dump of one channel, byte-by-byte against the RAM model.
    task automatic dump_ch(input int ch, input int wa);
        logic [7:0] b, e;
        bit ok, c;
        int bad;
        bad = 0;
        waddr = ADDR_W'(wa);
        start_cmd(2'b10, 6'(ch), 8'($urandom));
        for (int i = 0; i < ENTRIES; i++) begin
            get_resp(b, ok, c);
            e = mem[ch-1][(wa + i) % ENTRIES];
            n_chk++;
            if (!ok) begin
                n_fail++; cmd_rdy = 1'b0;
                $display("FAIL dump_timeout ch=%0d byte=%0d: no send_resp, required %h", ch, i, e);
                return;
            end
            ack();
            if (b !== e || (i == 0 && !c)) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL dump_byte ch=%0d idx=%0d: got %h clr=%0d, required %h", ch, i, b, c, e);
            end
        end
        n_chk++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (send_resp) begin
                n_fail++;
                $display("FAIL dump_extra ch=%0d: send_resp after %0d bytes, required none", ch, ENTRIES);
                break;
            end
        end
    endtask

    task automatic test_dump();
        fill_ram();
        for (int ch = 1; ch <= NUM_CH; ch++) dump_ch(ch, 5);
        dump_ch($urandom_range(1, NUM_CH), $urandom_range(0, ENTRIES - 1));
        dump_ch(1, ENTRIES - 1);
    endtask

    task automatic test_bad_dump();
        logic [7:0] b;
        bit ok, c;
        logic [15:0] cmds [3];
        cmds[0] = {2'b10, 6'd0, 8'h00};
        cmds[1] = {2'b10, 6'(NUM_CH + 1), 8'h00};
        cmds[2] = {2'b11, 6'($urandom), 8'($urandom)};
        for (int k = 0; k < 3; k++) begin
            start_cmd(cmds[k][15:14], cmds[k][13:8], cmds[k][7:0]);
            get_resp(b, ok, c);
            n_chk++;
            if (!ok || b !== 8'hEE || !c) begin
                n_fail++; cmd_rdy = 1'b0;
                $display("FAIL bad_dump cmd=%h: ok=%0d got %h clr=%0d, required EE", cmds[k], ok, b, c);
            end
            if (ok) ack();
            n_chk++;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (send_resp) begin
                    n_fail++;
                    $display("FAIL bad_dump_extra cmd=%h: extra send_resp, required single EE", cmds[k]);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [7:0] b;
        bit ok, c;
        int ch;
        ch = $urandom_range(1, NUM_CH);
        waddr = ADDR_W'($urandom_range(0, ENTRIES - 1));
        start_cmd(2'b10, 6'(ch), 8'h00);
        for (int i = 0; i <= 100; i++) begin
            get_resp(b, ok, c);
            if (!ok) break;
            if (i < 100) ack();
        end
        n_chk++;
        if (!ok) begin
            n_fail++; cmd_rdy = 1'b0;
            $display("FAIL rst_dump_reach: dump stalled before byte 100, required 101 bytes");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_reset();
        n_chk++;
        if (addr_ptr !== '0 || send_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_dump_state: ptr=%0d send=%b, required 0 0", addr_ptr, send_resp);
        end
        n_chk++;
        for (int i = 0; i < 300; i++) begin
            resp_sent = (i % 7 == 3);
            @(negedge clk);
            if (send_resp) begin
                n_fail++;
                $display("FAIL rst_dump_quiet: send_resp %0d cycles after reset, required none", i);
                break;
            end
        end
        resp_sent = 1'b0;
        reg_cmd(2'b00, NUM_CH + 2, 8'h00, 1'b0);
        check_ports("rst_dump");
    endtask

`ifdef CMD_CFG_DUMP_ABORT_EN
    task automatic test_abort();
        logic [7:0] b;
        bit ok, c;
        waddr = '0;
        start_cmd(2'b10, 6'd1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            get_resp(b, ok, c);
            if (!ok) break;
            if (i < 9) ack();
        end
        cmd = {2'b11, 6'($urandom), 8'($urandom)};
        cmd_rdy = 1'b1;
        ack();
        get_resp(b, ok, c);
        n_chk++;
        if (!ok || b !== 8'hEE || !c) begin
            n_fail++; cmd_rdy = 1'b0;
            $display("FAIL abort_resp: ok=%0d got %h clr=%0d, required EE with clr", ok, b, c);
        end
        if (ok) ack();
        n_chk++;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (send_resp) begin
                n_fail++;
                $display("FAIL abort_quiet: send_resp after abort, required none");
                break;
            end
        end
        reg_cmd(2'b00, NUM_CH + 3, 8'h00, 1'b0);
    endtask
`endif

    initial begin
        ref_reset();
        test_reset();
        test_write_read();
        test_unmapped();
        test_random();
        test_dump();
        test_bad_dump();
        test_reset_mid_dump();
`ifdef CMD_CFG_DUMP_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_cfg_mc.md
Name: cmd_cfg_mc

Overview:
Parametrised successor to the analyzer command/config unit. It decodes 16-bit host commands arriving from UART_wrapper, maintains the trigger/config register file, and answers with one-byte responses. It dumps any of NUM_CH RAMqueue channels of ENTRIES bytes, oldest sample first. It sits between UART_wrapper and the capture/trigger logic.

Parameters:
NUM_CH, 5, number of capture channels (1..52)
ENTRIES, 384, samples per channel RAM
ADDR_W, $clog2(ENTRIES), RAM address width
DATA_W, 8, sample width; must stay 8, since responses are one byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd  in  16  {opcode[15:14], addr[13:8], data[7:0]} from UART_wrapper
cmd_rdy  in  1  command valid (level, held until cleared)
clr_cmd_rdy  out  1  one-cycle pulse when a command is accepted
resp  out  8  response byte, stable from send_resp until resp_sent
send_resp  out  1  one-cycle pulse to start response transmission
resp_sent  in  1  one-cycle pulse when the UART has finished sending resp
set_capture_done  in  1  capture unit finished
waddr  in  ADDR_W  next RAM write address (= oldest sample)
rdata  in  NUM_CH*8  packed RAM read data; channel n at [8n-1:8n-8]
addr_ptr  out  ADDR_W  RAM read address, shared by all channels
trig_cfg  out  6  register 0x00
ch_trig_cfg  out  NUM_CH*5  per-channel trigger configuration
decimator  out  4
VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL  out  8 each
trig_pos  out  ADDR_W

Behaviour:
- Register map (B = NUM_CH+1):
  - 0x00 trig_cfg
  - 0x01..NUM_CH ch_trig_cfg[n]
  - B decimator
  - B+1 VIH, B+2 VIL
  - B+3 matchH, B+4 matchL
  - B+5 maskH, B+6 maskL
  - B+7 baud_cntH, B+8 baud_cntL
  - B+9 trig_pos high bits, B+10 trig_pos[7:0]
  - Addresses above B+10 are unmapped.
- Reset values:
  - VIH=8'hAA, VIL=8'h55; all other registers 0.
  - resp=0, send_resp=0, clr_cmd_rdy=0, addr_ptr=0; state IDLE.
- Every cycle that set_capture_done=1, trig_cfg[4] is set. A host write in the same cycle wins for all bits except bit4, which is ORed.
- States:
  - IDLE, on cmd_rdy: pulse clr_cmd_rdy and decode.
  - Opcode 00 (read): resp = register value, zero-extended; unmapped -> 8'hEE. Go to WAIT_SENT.
  - Opcode 01 (write): update the register, truncating to its width; resp = 8'hA5. Unmapped -> 8'hEE with no write. Go to WAIT_SENT.
  - Opcode 10 (dump): addr[5:0] selects channel 1..NUM_CH. Otherwise resp = 8'hEE and go to WAIT_SENT. Valid channel: addr_ptr <= waddr, count <= 0, go to DUMP_RD.
  - Opcode 11 (reserved): resp = 8'hEE, go to WAIT_SENT.
  - send_resp pulses on the cycle after decode.
  - WAIT_SENT: on resp_sent, go to IDLE.
  - DUMP_RD: one cycle to cover RAM read latency.
  - DUMP_SEND: resp <= selected channel's rdata byte, pulse send_resp, go to DUMP_WAIT.
  - DUMP_WAIT: on resp_sent, if count == ENTRIES-1, go to IDLE. Otherwise count++ and addr_ptr++, wrapping ENTRIES-1 -> 0, then go to DUMP_RD.
- Exactly ENTRIES bytes are sent per dump, oldest first.
- cmd_rdy is ignored outside IDLE and stays pending, unless the optional feature applies.
- rst asserted in any state returns everything to reset values on the next edge. No send_resp is issued afterwards.

Optional Feature:
CMD_CFG_DUMP_ABORT_EN.
- Defined: in DUMP_WAIT, a pending cmd_rdy with opcode 11 aborts the dump once the current byte is sent. The block pulses clr_cmd_rdy, sends 8'hEE, passes through WAIT_SENT, and returns to IDLE.
- Undefined: a dump always runs to completion.

Decomposition:
- Package cmd_cfg_pkg:
  - opcode enum (RD, WR, DUMP, RSVD)
  - ACK=8'hA5, NAK=8'hEE
  - register offset localparams relative to B
  - state enum
- Sub-module cmd_cfg_regfile:
  - register storage, address decode and reset values
  - set_capture_done OR into trig_cfg[4]
  - outputs read data plus an unmapped flag

Test Plan:
- Write 0x01..0x11 to addresses 0..16, NUM_CH=5, with set_capture_done=1 -> each write answered 0xA5.
- Read back the same addresses -> addr 0 returns 0x11 (bit4 set by capture done); addr n returns n+1 truncated to register width.
- Write and read addr 0x20 (unmapped) -> 0xEE for both; no register changes.
- Fill the RAMs so that the byte at address k is k[7:0]+offset, with waddr=5; dump channels 1..5 -> 384 bytes each, starting with the byte at address 5, wrapping 383 -> 0.
- Dump with channel 0, then channel 6, then opcode 11 -> each returns a single 0xEE.
- Assert rst mid-dump at byte 100 -> no further send_resp; VIH reads back 0xAA. With CMD_CFG_DUMP_ABORT_EN, opcode 11 sent mid-dump -> dump stops, 0xEE is returned, state is IDLE.
